// File: rtl/lut_bram_ctrl.sv
// lut_bram_ctrl: sequences a dual-port LUT BRAM; port A loads the table, port B serves 2-cycle lookups (optional address clamp: LUT_CLAMP_EN)
module lut_bram_ctrl #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_LINES = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_start_i,
  input  logic [ADDR_LINES:0]   cfg_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [RAM_WIDTH-1:0]  wr_data_i,
  output logic                  tbl_ready_o,
  input  logic                  q_valid_i,
  output logic                  q_ready_o,
  input  logic [ADDR_LINES-1:0] q_addr_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [RAM_WIDTH-1:0]  r_data_o,
  output logic                  r_oor_o,
  output logic [ADDR_LINES-1:0] bram_addra_o,
  output logic [RAM_WIDTH-1:0]  bram_dina_o,
  output logic                  bram_ena_o,
  output logic                  bram_wea_o,
  output logic                  bram_regcea_o,
  output logic                  bram_rstna_o,
  output logic [ADDR_LINES-1:0] bram_addrb_o,
  output logic                  bram_enb_o,
  output logic                  bram_web_o,
  output logic                  bram_regceb_o,
  output logic                  bram_rstnb_o,
  input  logic [RAM_WIDTH-1:0]  bram_doutb_i
);
  localparam logic [ADDR_LINES:0] DEPTH = (ADDR_LINES+1)'(1) << ADDR_LINES;
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, DRAIN} state_t;
  state_t                state_q, state_d;
  logic [ADDR_LINES:0]   len_q, len_d;
  logic [ADDR_LINES-1:0] wptr_q, wptr_d;
  logic                  v1_q, v1_d, v2_q, v2_d, oor1_q, oor1_d, oor2_q, oor2_d;
  logic                  cfg_ok, stall, wr_fire, q_fire, oor, run;
  // handshakes, BRAM port drive and lookup pipeline advance
  always_comb begin
    cfg_ok        = cfg_start_i && cfg_len_i != '0 && cfg_len_i <= DEPTH;
    stall         = v2_q & ~r_ready_i;
    run           = state_q == ACTIVE || state_q == DRAIN;
    wr_ready_o    = state_q == LOAD;
    tbl_ready_o   = state_q == ACTIVE && !cfg_ok;
    q_ready_o     = tbl_ready_o & ~stall;
    wr_fire       = wr_valid_i & wr_ready_o;
    q_fire        = q_valid_i & q_ready_o;
    oor           = {1'b0, q_addr_i} >= len_q;
    bram_ena_o    = wr_fire;
    bram_wea_o    = wr_fire;
    bram_addra_o  = wptr_q;
    bram_dina_o   = wr_data_i;
    bram_regcea_o = 1'b0;
    bram_rstna_o  = 1'b1;
    bram_enb_o    = q_fire;
`ifdef LUT_CLAMP_EN
    bram_addrb_o  = oor ? ADDR_LINES'(len_q - 1'b1) : q_addr_i;
`else
    bram_addrb_o  = q_addr_i;
`endif
    bram_web_o    = 1'b0;
    bram_regceb_o = run & ~stall;
    bram_rstnb_o  = rstn_i;
    v1_d          = stall ? v1_q : q_fire;
    v2_d          = stall ? v2_q : v1_q;
    oor1_d        = stall ? oor1_q : q_fire & oor;
    oor2_d        = stall ? oor2_q : oor1_q;
    r_valid_o     = v2_q;
    r_oor_o       = oor2_q;
    r_data_o      = bram_doutb_i;
  end
  // table (re)load sequencing: length latch, write pointer and state transitions
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wptr_d  = wptr_q;
    case (state_q)
      IDLE: if (cfg_ok) begin
        len_d   = cfg_len_i;
        wptr_d  = '0;
        state_d = LOAD;
      end
      LOAD: if (wr_fire) begin
        wptr_d  = wptr_q + 1'b1;
        state_d = {1'b0, wptr_q} == len_q - 1'b1 ? ACTIVE : LOAD;
      end
      ACTIVE: if (cfg_ok) begin
        len_d   = cfg_len_i;
        state_d = DRAIN;
      end
      default: if (!v1_q && !v2_q) begin
        wptr_d  = '0;
        state_d = LOAD;
      end
    endcase
  end
  // state and pipeline registers; reset discards any in-flight lookups
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      wptr_q  <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      oor1_q  <= 1'b0;
      oor2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      oor1_q  <= oor1_d;
      oor2_q  <= oor2_d;
    end
  end
endmodule

// File: tb/tb_lut_bram_ctrl.sv
// tb_lut_bram_ctrl: table-driven bench for lut_bram_ctrl with a behavioural 2-stage BRAM (honours LUT_CLAMP_EN)
module tb_lut_bram_ctrl;
  logic        clk = 1'b0, rstn = 1'b1;
  logic        cfg_start, wr_valid, q_valid, r_ready;
  logic [4:0]  cfg_len;
  logic [31:0] wr_data;
  logic [3:0]  q_addr;
  logic        wr_ready, tbl_ready, q_ready, r_valid, r_oor;
  logic [31:0] r_data, dina, doutb;
  logic [3:0]  addra, addrb;
  logic        ena, wea, regcea, rstna, enb, web, regceb, rstnb;
  logic [31:0] mem [16];
  logic [31:0] lat, oreg;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  lut_bram_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .cfg_start_i(cfg_start), .cfg_len_i(cfg_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .tbl_ready_o(tbl_ready), .q_valid_i(q_valid), .q_ready_o(q_ready), .q_addr_i(q_addr),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_oor_o(r_oor),
    .bram_addra_o(addra), .bram_dina_o(dina), .bram_ena_o(ena), .bram_wea_o(wea),
    .bram_regcea_o(regcea), .bram_rstna_o(rstna),
    .bram_addrb_o(addrb), .bram_enb_o(enb), .bram_web_o(web), .bram_regceb_o(regceb),
    .bram_rstnb_o(rstnb), .bram_doutb_i(doutb)
  );

  // behavioural BRAM: write on port A, read latch plus output register on port B
  always @(posedge clk) begin
    if (ena && wea) mem[addra] <= dina;
    if (enb) lat <= mem[addrb];
    if (regceb) oreg <= lat;
  end
  assign doutb = oreg;

  typedef struct {
    logic st; logic [4:0] len; logic wv; logic [31:0] wd; logic qv; logic [3:0] qa; logic rr;
    logic e_wr; logic e_ena; logic [3:0] e_addra; logic e_tbl; logic e_qrdy; logic e_enb;
    logic [3:0] e_addrb; logic e_rce; logic e_rv; logic [31:0] e_rd; logic e_oor;
  } vec_t;

  function automatic vec_t mk(logic st, logic [4:0] len, logic wv, logic [31:0] wd, logic qv,
                              logic [3:0] qa, logic rr, logic e_wr, logic e_ena, logic [3:0] e_addra,
                              logic e_tbl, logic e_qrdy, logic e_enb, logic [3:0] e_addrb,
                              logic e_rce, logic e_rv, logic [31:0] e_rd, logic e_oor);
    vec_t t;
    t.st = st; t.len = len; t.wv = wv; t.wd = wd; t.qv = qv; t.qa = qa; t.rr = rr;
    t.e_wr = e_wr; t.e_ena = e_ena; t.e_addra = e_addra; t.e_tbl = e_tbl; t.e_qrdy = e_qrdy;
    t.e_enb = e_enb; t.e_addrb = e_addrb; t.e_rce = e_rce; t.e_rv = e_rv; t.e_rd = e_rd; t.e_oor = e_oor;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    cfg_start = t.st; cfg_len = t.len; wr_valid = t.wv; wr_data = t.wd;
    q_valid = t.qv; q_addr = t.qa; r_ready = t.rr;
  endtask

  task automatic check(input vec_t t, input string nm, input int idx);
    logic [84:0] exp_v, got_v;
    exp_v = {t.e_wr, t.e_ena, t.e_ena, t.e_ena ? t.e_addra : 4'd0, t.e_ena ? t.wd : 32'd0,
             t.e_tbl, t.e_qrdy, t.e_enb, t.e_enb ? t.e_addrb : 4'd0, t.e_rce, t.e_rv,
             t.e_rv ? t.e_rd : 32'd0, t.e_oor, 1'b0, 1'b0, 1'b1, rstn};
    got_v = {wr_ready, ena, wea, t.e_ena ? addra : 4'd0, t.e_ena ? dina : 32'd0,
             tbl_ready, q_ready, enb, t.e_enb ? addrb : 4'd0, regceb, r_valid,
             t.e_rv ? r_data : 32'd0, r_oor, web, regcea, rstna, rstnb};
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, got_v, exp_v);
    end
  endtask

`ifdef LUT_CLAMP_EN
  localparam logic [3:0]  OA6 = 4'd3, OA3 = 4'd1;
  localparam logic [31:0] D6 = 32'hA3, D3 = 32'hB1;
`else
  localparam logic [3:0]  OA6 = 4'd6, OA3 = 4'd3;
  localparam logic [31:0] D6 = 32'hEE06, D3 = 32'hA3;
`endif

  vec_t tv[$], hv[$];
  vec_t z;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hEE00 + 32'(i);
    lat = '0; oreg = '0;
    z = mk(0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,0,0,0);
    //         st len wv wd     qv qa  rr  wr ena ada tbl qr enb adb rce rv rd      oor
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(1,4, 0,0,     0,0,  1,  0,0,0,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(0,0, 1,'hA0,  0,0,  1,  1,1,0,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  1,0,0,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(0,0, 1,'hA1,  0,0,  1,  1,1,1,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(1,2, 1,'hA2,  0,0,  1,  1,1,2,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  1,0,0,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  1,0,0,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(0,0, 1,'hA3,  0,0,  1,  1,1,3,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     1,0,  1,  0,0,0,  1,1,1,0,  1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     1,1,  1,  0,0,0,  1,1,1,1,  1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     1,2,  1,  0,0,0,  1,1,1,2,  1,1,'hA0,  0));
    tv.push_back(mk(0,0, 0,0,     1,3,  1,  0,0,0,  1,1,1,3,  1,1,'hA1,  0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,1,'hA2,  0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,1,'hA3,  0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     1,3,  1,  0,0,0,  1,1,1,3,  1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     1,2,  1,  0,0,0,  1,1,1,2,  1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     1,1,  0,  0,0,0,  1,0,0,0,  0,1,'hA3,  0));
    tv.push_back(mk(0,0, 0,0,     1,1,  0,  0,0,0,  1,0,0,0,  0,1,'hA3,  0));
    tv.push_back(mk(0,0, 0,0,     1,1,  0,  0,0,0,  1,0,0,0,  0,1,'hA3,  0));
    tv.push_back(mk(0,0, 0,0,     1,1,  1,  0,0,0,  1,1,1,1,  1,1,'hA3,  0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,1,'hA2,  0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,1,'hA1,  0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     1,6,  1,  0,0,0,  1,1,1,OA6,1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,1,D6,    1));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,0,0,     0));
    tv.push_back(mk(1,0, 0,0,     1,0,  1,  0,0,0,  1,1,1,0,  1,0,0,     0));
    tv.push_back(mk(1,17,0,0,     1,1,  1,  0,0,0,  1,1,1,1,  1,0,0,     0));
    tv.push_back(mk(1,2, 0,0,     1,2,  1,  0,0,0,  0,0,0,0,  1,1,'hA0,  0));
    tv.push_back(mk(0,0, 0,0,     1,2,  1,  0,0,0,  0,0,0,0,  1,1,'hA1,  0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  0,0,0,0,  1,0,0,     0));
    tv.push_back(mk(0,0, 1,'hB0,  0,0,  1,  1,1,0,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(0,0, 1,'hB1,  0,0,  1,  1,1,1,  0,0,0,0,  0,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     1,1,  1,  0,0,0,  1,1,1,1,  1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     1,0,  1,  0,0,0,  1,1,1,0,  1,0,0,     0));
    tv.push_back(mk(0,0, 0,0,     1,3,  1,  0,0,0,  1,1,1,OA3,1,1,'hB1,  0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,1,'hB0,  0));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,1,D3,    1));
    tv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  1,1,0,0,  1,0,0,     0));
    hv.push_back(mk(1,4, 0,0,     0,0,  1,  0,0,0,  0,0,0,0,  1,0,0,     0));
    hv.push_back(mk(0,0, 0,0,     0,0,  1,  0,0,0,  0,0,0,0,  1,0,0,     0));
    hv.push_back(mk(0,0, 1,'hC0,  0,0,  1,  1,1,0,  0,0,0,0,  0,0,0,     0));
    hv.push_back(mk(0,0, 1,'hC1,  0,0,  1,  1,1,1,  0,0,0,0,  0,0,0,     0));

    drive(z);
    #1 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check(z, "reset", 0);
    rstn = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1 check(tv[i], "table", i);
    end
    for (int i = 0; i < hv.size(); i++) begin
      @(negedge clk);
      drive(hv[i]);
      #1 check(hv[i], "reload", i);
    end
    @(negedge clk);
    drive(mk(0,0,1,'hC2,1,0,1, 0,0,0,0,0,0,0,0,0,0,0));
    #2 rstn = 1'b0;
    #1 check(z, "async_rst", 0);
    @(negedge clk);
    #1 check(z, "rst_hold", 0);
    rstn = 1'b1;
    drive(mk(0,0,1,'hC3,1,0,1, 0,0,0,0,0,0,0,0,0,0,0));
    #1 check(mk(0,0,1,'hC3,1,0,1, 0,0,0,0,0,0,0,0,0,0,0), "post_rst_idle", 0);
    @(negedge clk);
    drive(mk(1,1,0,0,0,0,1, 0,0,0,0,0,0,0,0,0,0,0));
    #1 check(mk(1,1,0,0,0,0,1, 0,0,0,0,0,0,0,0,0,0,0), "post_rst_start", 0);
    @(negedge clk);
    drive(mk(0,0,1,'hD0,0,0,1, 1,1,0,0,0,0,0,0,0,0,0));
    #1 check(mk(0,0,1,'hD0,0,0,1, 1,1,0,0,0,0,0,0,0,0,0), "post_rst_load", 0);
    @(negedge clk);
    drive(z);
    #1 check(mk(0,0,0,0,0,0,1, 0,0,0,1,1,0,0,1,0,0,0), "post_rst_active", 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
